// File: rtl/vmem_fill_ctrl.sv
// Rectangle fill engine for the VGA frame buffer.
// Shares one memory port with scan-out; scan-out always wins.
module vmem_fill_ctrl #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_valid,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x0,
  input  logic [9:0]  cmd_x1,
  input  logic [8:0]  cmd_y0,
  input  logic [8:0]  cmd_y1,
  input  logic [23:0] cmd_color,
  output logic [18:0] mem_addr,
  output logic        mem_we,
  output logic [23:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [9:0]  V_LIM = 10'(V_RES);

  state_t      state;
  state_t      state_nx;
  logic [9:0]  cur_x;
  logic [8:0]  cur_y;
  logic [9:0]  x0_q;
  logic [9:0]  x1_q;
  logic [8:0]  y1_q;
  logic [23:0] color_q;
  logic        err_q;
  logic        cmd_ok;
  logic        accept;
  logic        wr_go;
  logic        last_x;
  logic        last_y;
  logic        unused_vaddr;

  assign unused_vaddr = v_addr[9];

  assign cmd_ok = (cmd_x0 <= cmd_x1) &&
                  (cmd_y0 <= cmd_y1) &&
                  ({1'b0, cmd_x1} < H_LIM) &&
                  ({1'b0, cmd_y1} < V_LIM);

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  // A write only happens on cycles scan-out leaves the port free
  assign wr_go     = (state == FILL) && !vga_valid && !rst;
  assign last_x    = (cur_x == x1_q);
  assign last_y    = (cur_y == y1_q);

  assign busy      = (state == FILL);
  assign done      = (state == DONE);
  assign err       = err_q;
  assign mem_wdata = color_q;

  always_comb begin
    state_nx = state;
    mem_we   = 1'b0;
    mem_addr = {cur_x, cur_y};
    case (state)
      IDLE: if (accept && cmd_ok) state_nx = FILL;
      FILL: if (wr_go && last_x && last_y) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (vga_valid) begin
      mem_addr = {h_addr, v_addr[8:0]};
    end else begin
      mem_we = wr_go;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cur_x   <= '0;
      cur_y   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= accept && !cmd_ok;
      if (accept && cmd_ok) begin
        cur_x   <= cmd_x0;
        cur_y   <= cmd_y0;
        x0_q    <= cmd_x0;
        x1_q    <= cmd_x1;
        y1_q    <= cmd_y1;
        color_q <= cmd_color;
      end else if (wr_go && !(last_x && last_y)) begin
        // Raster order; position parks on (x1,y1) after the final pixel
        if (last_x) begin
          cur_x <= x0_q;
          cur_y <= cur_y + 9'd1;
        end else begin
          cur_x <= cur_x + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vmem_fill_ctrl.sv
// Bench for vmem_fill_ctrl: command table plus reset corner sequences.
// Expected writes are queued at issue time and popped by the write monitor.
module tb_vmem_fill_ctrl;

  logic        clk;
  logic        rst;
  logic        vga_valid;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x0;
  logic [9:0]  cmd_x1;
  logic [8:0]  cmd_y0;
  logic [8:0]  cmd_y1;
  logic [23:0] cmd_color;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [23:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  vmem_fill_ctrl #(.H_RES(640), .V_RES(480)) dut (
    .clk       (clk),
    .rst       (rst),
    .vga_valid (vga_valid),
    .h_addr    (h_addr),
    .v_addr    (v_addr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_x1    (cmd_x1),
    .cmd_y0    (cmd_y0),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    int          x0;
    int          x1;
    int          y0;
    int          y1;
    logic [23:0] color;
    bit          exp_err;
    bit          vga_tog;
    bit          hold;
  } cmd_vec_t;

  typedef struct {
    logic [18:0] addr;
    logic [23:0] data;
  } exp_wr_t;

  exp_wr_t sb[$];
  int      n_total = 0;
  int      n_pass  = 0;
  bit      vga_tog = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(posedge clk) begin
    #1;
    vga_valid = vga_tog ? ~vga_valid : 1'b0;
    h_addr    = 10'($urandom);
    v_addr    = 10'($urandom);
  end

  always @(negedge clk) begin
    exp_wr_t e;
    if (!rst) begin
      if (vga_valid) begin
        chk("arb_we", 64'(mem_we), 64'(0));
        chk("arb_addr", 64'(mem_addr), 64'({h_addr, v_addr[8:0]}));
      end else if (mem_we) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 64'(mem_we), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("waddr", 64'(mem_addr), 64'(e.addr));
          chk("wdata", 64'(mem_wdata), 64'(e.data));
        end
      end
    end
  end

  task automatic drive_cmd(input cmd_vec_t v);
    cmd_x0    = 10'(v.x0);
    cmd_x1    = 10'(v.x1);
    cmd_y0    = 9'(v.y0);
    cmd_y1    = 9'(v.y1);
    cmd_color = v.color;
    cmd_valid = 1'b1;
  endtask

  task automatic scramble;
    cmd_x0    = 10'($urandom_range(639));
    cmd_x1    = 10'($urandom_range(639));
    cmd_y0    = 9'($urandom_range(479));
    cmd_y1    = 9'($urandom_range(479));
    cmd_color = 24'($urandom);
  endtask

  task automatic push_rect(input cmd_vec_t v, output int n);
    exp_wr_t e;
    n = 0;
    for (int y = v.y0; y <= v.y1; y++) begin
      for (int x = v.x0; x <= v.x1; x++) begin
        e.addr = {10'(x), 9'(y)};
        e.data = v.color;
        sb.push_back(e);
        n++;
      end
    end
  endtask

  task automatic run_cmd(input cmd_vec_t v);
    int n;
    int cyc;
    bit fin;
    n = 0;
    if (!v.exp_err) push_rect(v, n);
    vga_tog = v.vga_tog;
    @(posedge clk); #2;
    drive_cmd(v);
    @(negedge clk);
    chk("cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk); #2;
    if (!v.hold) begin
      cmd_valid = 1'b0;
      scramble();
    end
    cyc = 0;
    fin = 0;
    while (!fin && cyc < 2 * n + 20) begin
      @(negedge clk);
      cyc++;
      if (done || err) begin
        fin = 1;
      end else begin
        chk("busy", 64'(busy), 64'(!v.exp_err));
        if (v.hold) begin
          chk("hold_ready", 64'(cmd_ready), 64'(0));
          scramble();
        end
      end
    end
    cmd_valid = 1'b0;
    chk("finished", 64'(fin), 64'(1));
    if (fin) begin
      chk("done", 64'(done), 64'(!v.exp_err));
      chk("err", 64'(err), 64'(v.exp_err));
      chk("busy_end", 64'(busy), 64'(0));
      if (v.exp_err) chk("err_cycles", 64'(cyc), 64'(1));
      else if (!v.vga_tog) chk("fill_cycles", 64'(cyc), 64'(n + 1));
    end
    @(negedge clk);
    chk("pulse_clr", 64'({done, err}), 64'(0));
    chk("ready_back", 64'(cmd_ready), 64'(1));
    chk("sb_empty", 64'(sb.size()), 64'(0));
    sb.delete();
    vga_tog = 0;
  endtask

  cmd_vec_t vecs[10];

  initial begin
    int n;
    cmd_vec_t v;
    vecs[0] = '{2, 3, 5, 5, 24'hFF0000, 0, 0, 0};
    vecs[1] = '{0, 1, 0, 1, 24'h00FF00, 0, 1, 0};
    vecs[2] = '{10, 9, 0, 0, 24'h123456, 1, 0, 0};
    vecs[3] = '{0, 0, 0, 480, 24'h123456, 1, 0, 0};
    vecs[4] = '{7, 7, 9, 9, 24'h0000FF, 0, 0, 0};
    vecs[5] = '{0, 640, 0, 0, 24'h777777, 1, 0, 0};
    vecs[6] = '{5, 8, 3, 2, 24'h777777, 1, 0, 0};
    vecs[7] = '{630, 639, 476, 479, 24'hA5A55A, 0, 1, 1};
    vecs[8] = '{0, 639, 470, 479, 24'hC0FFEE, 0, 0, 0};
    vecs[9] = '{100, 102, 200, 203, 24'h314159, 0, 1, 0};

    rst       = 1'b1;
    vga_valid = 1'b0;
    h_addr    = '0;
    v_addr    = '0;
    cmd_valid = 1'b0;
    cmd_x0    = '0;
    cmd_x1    = '0;
    cmd_y0    = '0;
    cmd_y1    = '0;
    cmd_color = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_pulses", 64'({done, err}), 64'(0));
    chk("rst_we", 64'(mem_we), 64'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(cmd_ready), 64'(1));
    chk("idle_addr", 64'(mem_addr), 64'(0));
    chk("idle_wdata", 64'(mem_wdata), 64'(0));

    for (int i = 0; i < 10; i++) run_cmd(vecs[i]);

    // reset in the middle of a fill
    v = '{0, 9, 0, 0, 24'hABCDEF, 0, 0, 0};
    push_rect(v, n);
    @(posedge clk); #2;
    drive_cmd(v);
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_we", 64'(mem_we), 64'(0));
    chk("abort_addr", 64'(mem_addr), 64'(0));
    chk("abort_wdata", 64'(mem_wdata), 64'(0));
    chk("abort_ready", 64'(cmd_ready), 64'(1));
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done), 64'(0));
    end
    run_cmd(vecs[4]);

    // reset beats a simultaneous handshake
    @(posedge clk); #2;
    rst = 1'b1;
    drive_cmd(vecs[0]);
    @(negedge clk);
    chk("rst_hs_ready", 64'(cmd_ready), 64'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    cmd_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_hs_busy", 64'(busy), 64'(0));
    end
    run_cmd(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vmem_fill_ctrl.md
VMEM_FILL_CTRL -- requirements
Module: vmem_fill_ctrl

Interface
REQ-001 Parameter H_RES, default 640, visible pixel columns; legal x range is 0..H_RES-1.
REQ-002 Parameter V_RES, default 480, visible pixel rows; legal y range is 0..V_RES-1.
REQ-003 clk  in  1  single clock, shared with the VGA pixel clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 vga_valid  in  1  VGA active-display flag; 1 = memory port reserved for scan-out read.
REQ-006 h_addr  in  10  VGA scan column.
REQ-007 v_addr  in  10  VGA scan row; only bits [8:0] are used.
REQ-008 cmd_valid  in  1  fill command offered.
REQ-009 cmd_ready  out  1  fill command accepted when cmd_valid && cmd_ready.
REQ-010 cmd_x0, cmd_x1  in  10 each  inclusive rectangle column bounds.
REQ-011 cmd_y0, cmd_y1  in  9 each  inclusive rectangle row bounds.
REQ-012 cmd_color  in  24  fill colour, {R,G,B}.
REQ-013 mem_addr  out  19  video memory address {x[9:0], y[8:0]}.
REQ-014 mem_we  out  1  video memory write enable.
REQ-015 mem_wdata  out  24  video memory write data.
REQ-016 busy  out  1  high while a fill is in progress.
REQ-017 done  out  1  one-cycle pulse when a fill completes.
REQ-018 err  out  1  one-cycle pulse when a command is rejected.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, FILL and DONE.
REQ-020 cmd_ready SHALL be 1 only in IDLE while rst is 0.
REQ-021 Command validity: x0<=x1, y0<=y1, x1<H_RES and y1<V_RES.
REQ-022 Accepting an invalid command SHALL pulse err on the next cycle and leave the FSM in IDLE with no write.
REQ-023 Accepting a valid command SHALL latch all cmd_* fields, set cur_x=x0 and cur_y=y0, and enter FILL on the next cycle.
REQ-024 busy SHALL be 1 exactly while in FILL.
REQ-025 Arbitration: vga_valid=1 SHALL select mem_addr={h_addr, v_addr[8:0]} and force mem_we=0 combinationally, in every state.
REQ-026 In FILL with vga_valid=0, mem_we SHALL be 1, mem_addr SHALL be {cur_x, cur_y} and mem_wdata SHALL be the latched colour, all in the same cycle.
REQ-027 Each write cycle SHALL advance the scan raster-order: cur_x+1; when cur_x==x1, cur_x=x0 and cur_y+1.
REQ-028 A FILL cycle with vga_valid=1 SHALL hold cur_x and cur_y, so no pixel is skipped or duplicated.
REQ-029 The write to (x1,y1) SHALL move the FSM to DONE on the next cycle.
REQ-030 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-031 A fill SHALL produce exactly (x1-x0+1)*(y1-y0+1) write cycles, each to a distinct address.
REQ-032 A 1x1 rectangle SHALL produce one write and then DONE.
REQ-033 Outside FILL with vga_valid=0, mem_we SHALL be 0 and mem_addr SHALL be {cur_x, cur_y}.
REQ-034 cmd_* changes after acceptance SHALL not affect the fill in progress.

Reset
REQ-035 While rst=1 on a clock edge, the FSM SHALL go to IDLE; busy, done, err and mem_we SHALL be 0; cur_x, cur_y and the latched colour SHALL be 0.
REQ-036 Reset during FILL SHALL abort the fill with no done pulse and no further writes.
REQ-037 Reset SHALL take priority over a simultaneous command handshake.

Verification
REQ-038 x0=2,x1=3,y0=5,y1=5,color=FF0000, vga_valid=0 -> writes to (2,5) and (3,5) on consecutive cycles, then done pulses once, then cmd_ready=1.
REQ-039 2x2 fill at (0,0) with vga_valid toggling 1,0,1,0... -> exactly 4 writes in order (0,0),(1,0),(0,1),(1,1); no write while vga_valid=1; mem_addr={h_addr,v_addr[8:0]} while vga_valid=1.
REQ-040 x0=10,x1=9 -> err pulses for one cycle, no mem_we, busy stays 0; repeat with y1=480 -> same response.
REQ-041 Full-screen fill 0..639 x 0..479 with vga_valid=0 -> 307200 writes, final write address {639,479}, then done.
REQ-042 rst=1 asserted mid-fill -> mem_we=0 and busy=0 from the next cycle, no done; a new command after reset fills correctly.
REQ-043 cmd_valid held high through FILL with changing fields -> no second acceptance until IDLE; the colour stays as latched.
